// File: rtl/planificador_niveles_pkg.sv
// Shared types, defaults and saturating level helpers for the pet level scheduler.
package planificador_niveles_pkg;
  localparam int NIVEL_W             = 2;
  localparam int PERIODO_HAMBRE_DEF  = 30;
  localparam int PERIODO_SALUD_DEF   = 60;
  localparam int DURACION_ACCION_DEF = 3;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    COMIENDO     = 2'd1,
    CURANDO      = 2'd2,
    ENFRIAMIENTO = 2'd3
  } estado_t;

  // Which requester was served last; drives the round-robin tie break.
  typedef enum logic {
    ULT_COMIDA   = 1'b0,
    ULT_MEDICINA = 1'b1
  } ultimo_t;

  typedef logic [NIVEL_W-1:0] nivel_t;
  localparam nivel_t NIVEL_MAX = '1;

  function automatic nivel_t nivel_inc(input nivel_t n);
    return (n == NIVEL_MAX) ? n : n + nivel_t'(1);
  endfunction

  function automatic nivel_t nivel_dec(input nivel_t n);
    return (n == '0) ? n : n - nivel_t'(1);
  endfunction
endpackage

// File: rtl/planificador_niveles_detector_flanco.sv
// One-bit rising-edge detector; output is combinational against the registered previous value.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic flanco
);
  logic prev_q, prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign flanco = d & ~prev_q;
endmodule

// File: rtl/planificador_niveles.sv
// Food/health level scheduler: arbitrates feed and medicine requests, runs timed
// actions and applies periodic decay of both levels.
module planificador_niveles
  import planificador_niveles_pkg::*;
#(
  parameter int PERIODO_HAMBRE  = PERIODO_HAMBRE_DEF,
  parameter int PERIODO_SALUD   = PERIODO_SALUD_DEF,
  parameter int DURACION_ACCION = DURACION_ACCION_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_seg,
  input  logic               Boton_Comida,
  input  logic               Boton_Medicina,
  input  logic               Activo_Comida,
  input  logic               Activo_Medicina,
  output logic [NIVEL_W-1:0] Nivel_Comida,
  output logic [NIVEL_W-1:0] Nivel_Salud,
  output logic               Concesion_Comida,
  output logic               Concesion_Medicina,
  output logic               Ocupado
);
  localparam int PMAX = (PERIODO_HAMBRE > PERIODO_SALUD) ? PERIODO_HAMBRE : PERIODO_SALUD;
  localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int AW   = (DURACION_ACCION > 1) ? $clog2(DURACION_ACCION) : 1;
  localparam logic [CW-1:0] HAMBRE_FIN = CW'(PERIODO_HAMBRE - 1);
  localparam logic [CW-1:0] SALUD_FIN  = CW'(PERIODO_SALUD - 1);
  localparam logic [AW-1:0] ACCION_FIN = AW'(DURACION_ACCION - 1);

  estado_t       estado_q, estado_d;
  ultimo_t       ultimo_q, ultimo_d;
  logic [AW-1:0] act_cnt_q, act_cnt_d;
  logic [CW-1:0] hambre_cnt_q, hambre_cnt_d;
  logic [CW-1:0] salud_cnt_q, salud_cnt_d;
  nivel_t        com_q, com_d, sal_q, sal_d;
  logic          pend_com_q, pend_com_d, pend_med_q, pend_med_d;
  logic          conc_com_q, conc_com_d, conc_med_q, conc_med_d;
  logic          ocupado_q, ocupado_d;
  logic          flanco_com, flanco_med;
  logic          eleg_com, eleg_med, otorga_com, otorga_med, en_reposo, en_accion;

  detector_flanco u_flanco_com (.clk(clk), .rst(reset), .d(Boton_Comida),   .flanco(flanco_com));
  detector_flanco u_flanco_med (.clk(clk), .rst(reset), .d(Boton_Medicina), .flanco(flanco_med));

  assign en_reposo = (estado_q == REPOSO);
  assign en_accion = (estado_q == COMIENDO) || (estado_q == CURANDO);
  assign eleg_com  = pend_com_q & Activo_Comida;
  assign eleg_med  = pend_med_q & Activo_Medicina;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= REPOSO;
      ultimo_q     <= ULT_MEDICINA;
      act_cnt_q    <= '0;
      hambre_cnt_q <= '0;
      salud_cnt_q  <= '0;
      com_q        <= NIVEL_MAX;
      sal_q        <= NIVEL_MAX;
      pend_com_q   <= 1'b0;
      pend_med_q   <= 1'b0;
      conc_com_q   <= 1'b0;
      conc_med_q   <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      ultimo_q     <= ultimo_d;
      act_cnt_q    <= act_cnt_d;
      hambre_cnt_q <= hambre_cnt_d;
      salud_cnt_q  <= salud_cnt_d;
      com_q        <= com_d;
      sal_q        <= sal_d;
      pend_com_q   <= pend_com_d;
      pend_med_q   <= pend_med_d;
      conc_com_q   <= conc_com_d;
      conc_med_q   <= conc_med_d;
      ocupado_q    <= ocupado_d;
    end
  end

  // Next state; on a tie the requester not served last wins.
  always_comb begin
    estado_d   = estado_q;
    otorga_com = 1'b0;
    otorga_med = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (eleg_com && (!eleg_med || ultimo_q == ULT_MEDICINA)) begin
          estado_d   = COMIENDO;
          otorga_com = 1'b1;
        end else if (eleg_med) begin
          estado_d   = CURANDO;
          otorga_med = 1'b1;
        end
      end
      COMIENDO, CURANDO: if (tick_seg && act_cnt_q == ACCION_FIN) estado_d = ENFRIAMIENTO;
      ENFRIAMIENTO:      if (tick_seg) estado_d = REPOSO;
      default:           estado_d = REPOSO;
    endcase
  end

  // Requests, action timer, levels and decay counters. Decisions use the current
  // state so a tick on a transition belongs to the state being left.
  always_comb begin
    pend_com_d = flanco_com | (pend_com_q & ~otorga_com & ~(en_reposo & ~Activo_Comida));
    pend_med_d = flanco_med | (pend_med_q & ~otorga_med & ~(en_reposo & ~Activo_Medicina));
    ultimo_d   = otorga_com ? ULT_COMIDA : (otorga_med ? ULT_MEDICINA : ultimo_q);

    act_cnt_d = act_cnt_q;
    if (!en_accion)    act_cnt_d = '0;
    else if (tick_seg) act_cnt_d = (act_cnt_q == ACCION_FIN) ? '0 : act_cnt_q + AW'(1);

    com_d        = com_q;
    hambre_cnt_d = hambre_cnt_q;
    if (tick_seg) begin
      if (estado_q == COMIENDO) com_d = nivel_inc(com_q);
      else if (hambre_cnt_q == HAMBRE_FIN) begin
        hambre_cnt_d = '0;
        com_d        = nivel_dec(com_q);
      end else hambre_cnt_d = hambre_cnt_q + CW'(1);
    end

    sal_d       = sal_q;
    salud_cnt_d = salud_cnt_q;
    if (com_q != '0) salud_cnt_d = '0;
    else if (tick_seg && estado_q != CURANDO) begin
      if (salud_cnt_q == SALUD_FIN) begin
        salud_cnt_d = '0;
        sal_d       = nivel_dec(sal_q);
      end else salud_cnt_d = salud_cnt_q + CW'(1);
    end
    if (tick_seg && estado_q == CURANDO) sal_d = nivel_inc(sal_q);
  end

  // Outputs registered off the next state so grants rise with the action state.
  always_comb begin
    conc_com_d = (estado_d == COMIENDO);
    conc_med_d = (estado_d == CURANDO);
    ocupado_d  = (estado_d != REPOSO);
  end

  assign Nivel_Comida       = com_q;
  assign Nivel_Salud        = sal_q;
  assign Concesion_Comida   = conc_com_q;
  assign Concesion_Medicina = conc_med_q;
  assign Ocupado            = ocupado_q;
endmodule

// File: tb/tb_planificador_niveles.sv
// Directed self-checking bench for planificador_niveles with short periods.
module tb_planificador_niveles;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_seg = 1'b0;
  logic       Boton_Comida = 1'b0, Boton_Medicina = 1'b0;
  logic       Activo_Comida = 1'b1, Activo_Medicina = 1'b1;
  logic [1:0] Nivel_Comida, Nivel_Salud;
  logic       Concesion_Comida, Concesion_Medicina, Ocupado;
  int         tests = 0, fails = 0;

  planificador_niveles #(.PERIODO_HAMBRE(4), .PERIODO_SALUD(4), .DURACION_ACCION(2)) dut (
    .clk(clk), .reset(reset), .tick_seg(tick_seg),
    .Boton_Comida(Boton_Comida), .Boton_Medicina(Boton_Medicina),
    .Activo_Comida(Activo_Comida), .Activo_Medicina(Activo_Medicina),
    .Nivel_Comida(Nivel_Comida), .Nivel_Salud(Nivel_Salud),
    .Concesion_Comida(Concesion_Comida), .Concesion_Medicina(Concesion_Medicina),
    .Ocupado(Ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_seg = 1'b1;
    step();
    tick_seg = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_com"},   {2'b0, Nivel_Comida}, 4'd3);
    chk({tag, "_sal"},   {2'b0, Nivel_Salud}, 4'd3);
    chk({tag, "_gcom"},  {3'b0, Concesion_Comida}, 4'd0);
    chk({tag, "_gmed"},  {3'b0, Concesion_Medicina}, 4'd0);
    chk({tag, "_ocup"},  {3'b0, Ocupado}, 4'd0);
  endtask

  task automatic do_reset();
    Boton_Comida = 1'b0; Boton_Medicina = 1'b0; tick_seg = 1'b0;
    Activo_Comida = 1'b1; Activo_Medicina = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();

    // Decay: food drops every 4 ticks, health untouched while fed
    tick_n(3);  chk("decay_t3", {2'b0, Nivel_Comida}, 4'd3);
    tick();     chk("decay_t4", {2'b0, Nivel_Comida}, 4'd2);
    tick_n(4);  chk("decay_t8", {2'b0, Nivel_Comida}, 4'd1);
    chk("decay_sal", {2'b0, Nivel_Salud}, 4'd3);

    // Starvation: food empty at 12, health drops at 16
    tick_n(3);  chk("starve_t11", {2'b0, Nivel_Comida}, 4'd1);
    tick();     chk("starve_t12", {2'b0, Nivel_Comida}, 4'd0);
    tick_n(3);  chk("starve_t15", {2'b0, Nivel_Salud}, 4'd3);
    tick();     chk("starve_t16", {2'b0, Nivel_Salud}, 4'd2);

    // Healing raises health; food floor stays at 0
    Boton_Medicina = 1'b1;
    step();     chk("heal_pend", {3'b0, Concesion_Medicina}, 4'd0);
    step();     chk("heal_grant", {3'b0, Concesion_Medicina}, 4'd1);
    chk("heal_ocup", {3'b0, Ocupado}, 4'd1);
    Boton_Medicina = 1'b0;
    tick();     chk("heal_sal", {2'b0, Nivel_Salud}, 4'd3);
    tick();     chk("heal_end_g", {3'b0, Concesion_Medicina}, 4'd0);
    chk("heal_cool", {3'b0, Ocupado}, 4'd1);
    tick();     chk("heal_idle", {3'b0, Ocupado}, 4'd0);
    tick();     chk("food_floor", {2'b0, Nivel_Comida}, 4'd0);

    // Blocked medicine request is dropped
    do_reset();
    Activo_Medicina = 1'b0;
    Boton_Medicina  = 1'b1;
    step();
    step();     chk("block_g", {3'b0, Concesion_Medicina}, 4'd0);
    chk("block_ocup", {3'b0, Ocupado}, 4'd0);
    Activo_Medicina = 1'b1;
    step();
    step();     chk("block_drop", {3'b0, Ocupado}, 4'd0);
    Boton_Medicina = 1'b0;

    // Feed from level 1
    do_reset();
    tick_n(8);  chk("feed_pre", {2'b0, Nivel_Comida}, 4'd1);
    Boton_Comida = 1'b1;
    step();
    step();     chk("feed_grant", {3'b0, Concesion_Comida}, 4'd1);
    Boton_Comida = 1'b0;
    tick();     chk("feed_t1", {2'b0, Nivel_Comida}, 4'd2);
    tick();     chk("feed_t2", {2'b0, Nivel_Comida}, 4'd3);
    chk("feed_end_g", {3'b0, Concesion_Comida}, 4'd0);
    chk("feed_cool", {3'b0, Ocupado}, 4'd1);
    tick();     chk("feed_idle", {3'b0, Ocupado}, 4'd0);

    // Tie after reset: food first, then medicine without another press
    do_reset();
    Boton_Comida = 1'b1; Boton_Medicina = 1'b1;
    step();
    step();     chk("tie_gcom", {3'b0, Concesion_Comida}, 4'd1);
    chk("tie_gmed0", {3'b0, Concesion_Medicina}, 4'd0);
    Boton_Comida = 1'b0; Boton_Medicina = 1'b0;
    tick();     chk("tie_sat", {2'b0, Nivel_Comida}, 4'd3);
    tick();     chk("tie_cool_g", {3'b0, Concesion_Comida}, 4'd0);
    chk("tie_cool_m", {3'b0, Concesion_Medicina}, 4'd0);
    tick();     chk("tie_idle", {3'b0, Ocupado}, 4'd0);
    step();     chk("tie_gmed", {3'b0, Concesion_Medicina}, 4'd1);

    // Reset halfway through healing takes effect before the next edge
    tick();     chk("mid_cur", {3'b0, Concesion_Medicina}, 4'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    step();
    reset = 1'b0;
    step();
    step();     chk("post_rst", {3'b0, Ocupado}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
